// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded control unit.
//   - opcode encodings (upper nibble of the instruction register)
//   - bit positions of the 16-bit control word, plus single-bit masks
//   - microstep count and the step positions the counter cares about
package cpu_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word bit indices, MSB to LSB
    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    localparam int CTRL_W = 16;

    // Single-bit masks so microcode rows read as OR-ed signal names
    localparam logic [CTRL_W-1:0] C_HLT = 16'h0001 << CTRL_HLT;
    localparam logic [CTRL_W-1:0] C_MI  = 16'h0001 << CTRL_MI;
    localparam logic [CTRL_W-1:0] C_RI  = 16'h0001 << CTRL_RI;
    localparam logic [CTRL_W-1:0] C_RO  = 16'h0001 << CTRL_RO;
    localparam logic [CTRL_W-1:0] C_IO  = 16'h0001 << CTRL_IO;
    localparam logic [CTRL_W-1:0] C_II  = 16'h0001 << CTRL_II;
    localparam logic [CTRL_W-1:0] C_AI  = 16'h0001 << CTRL_AI;
    localparam logic [CTRL_W-1:0] C_AO  = 16'h0001 << CTRL_AO;
    localparam logic [CTRL_W-1:0] C_EO  = 16'h0001 << CTRL_EO;
    localparam logic [CTRL_W-1:0] C_SU  = 16'h0001 << CTRL_SU;
    localparam logic [CTRL_W-1:0] C_BI  = 16'h0001 << CTRL_BI;
    localparam logic [CTRL_W-1:0] C_OI  = 16'h0001 << CTRL_OI;
    localparam logic [CTRL_W-1:0] C_CE  = 16'h0001 << CTRL_CE;
    localparam logic [CTRL_W-1:0] C_CO  = 16'h0001 << CTRL_CO;
    localparam logic [CTRL_W-1:0] C_J   = 16'h0001 << CTRL_J;
    localparam logic [CTRL_W-1:0] C_FI  = 16'h0001 << CTRL_FI;

    // Microstep sequencing
    localparam int         STEP_COUNT = 5;
    localparam logic [2:0] STEP_LAST  = 3'(STEP_COUNT - 1);
    localparam logic [2:0] STEP_HALT  = 3'd2;   // step where HLT parks

endpackage

// File: rtl/step_counter.sv
// Microstep counter for the control unit.
//   clk   : system clock, rising edge
//   clear : synchronous active-high reset, wins over everything
//   halt  : current opcode is HLT; parks the counter at STEP_HALT
//   step  : current microstep, 0..STEP_COUNT-1
//
//   step | meaning
//   -----+------------------------------------------
//   0    | fetch: PC -> MAR
//   1    | fetch: RAM -> IR, PC++
//   2    | execute 1 (HLT parks here)
//   3    | execute 2
//   4    | execute 3, wraps to 0
module step_counter
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       halt,
    output logic [2:0] step
);

    always_ff @(posedge clk) begin
        if (clear) begin
            step <= 3'd0;
        end else if (halt && (step == STEP_HALT)) begin
            step <= step;
        end else if (step == STEP_LAST) begin
            step <= 3'd0;
        end else begin
            step <= step + 3'd1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Microcoded control unit for a small 8-bit teaching CPU.
//   clk   : system clock, rising edge
//   clear : synchronous active-high reset; also blanks ctrl while high
//   instr : opcode, upper nibble of the instruction register
//   flags : registered ALU flags, bit1 = carry, bit0 = zero
//   ctrl  : control word, HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
//           (EO = ALU sum_out, SU = ALU subtract, FI = ALU flags load)
//   step  : current microstep, 0..4
// The only storage is the microstep counter; ctrl is a pure function of
// (clear, step, instr, flags).
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic [3:0]  instr,
    input  logic [1:0]  flags,
    output logic [15:0] ctrl,
    output logic [2:0]  step
);

    logic halt;

    assign halt = (instr == OP_HLT);

    step_counter u_step_counter (
        .clk   (clk),
        .clear (clear),
        .halt  (halt),
        .step  (step)
    );

    // Execute-phase rows; undefined opcodes fall to the zero default and
    // behave as NOP. Flags only matter in step 2 of JC/JZ.
    function automatic logic [15:0] exec_row(input logic [3:0] op,
                                             input logic [2:0] st,
                                             input logic [1:0] fl);
        logic [15:0] w;
        w = '0;
        case (st)
            3'd2: begin
                case (op)
                    OP_LDA, OP_ADD,
                    OP_SUB, OP_STA: w = C_IO | C_MI;
                    OP_LDI:         w = C_IO | C_AI;
                    OP_JMP:         w = C_IO | C_J;
                    OP_JC:          w = fl[1] ? (C_IO | C_J) : '0;
                    OP_JZ:          w = fl[0] ? (C_IO | C_J) : '0;
                    OP_OUT:         w = C_AO | C_OI;
                    OP_HLT:         w = C_HLT;
                    default:        w = '0;
                endcase
            end
            3'd3: begin
                case (op)
                    OP_LDA:         w = C_RO | C_AI;
                    OP_ADD, OP_SUB: w = C_RO | C_BI;
                    OP_STA:         w = C_AO | C_RI;
                    default:        w = '0;
                endcase
            end
            3'd4: begin
                case (op)
                    OP_ADD:         w = C_EO | C_AI | C_FI;
                    OP_SUB:         w = C_EO | C_AI | C_SU | C_FI;
                    default:        w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        ctrl = '0;
        if (!clear) begin
            case (step)
                3'd0:    ctrl = C_MI | C_CO;
                3'd1:    ctrl = C_RO | C_II | C_CE;
                default: ctrl = exec_row(instr, step, flags);
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic        clk;
    logic        clear;
    logic [3:0]  instr;
    logic [1:0]  flags;
    logic [15:0] ctrl;
    logic [2:0]  step;

    int n_tests = 0;
    int n_fail  = 0;

    control_unit dut (
        .clk   (clk),
        .clear (clear),
        .instr (instr),
        .flags (flags),
        .ctrl  (ctrl),
        .step  (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clear;
        logic [3:0]  instr;
        logic [1:0]  flags;
        logic [15:0] exp_ctrl;
        logic [2:0]  exp_step;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] ctrl;
        logic [2:0]  step;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void add(input logic c, input logic [3:0] i,
                                input logic [1:0] f, input logic [15:0] ec,
                                input logic [2:0] es, input string nm);
        vec_t v;
        v.clear = c; v.instr = i; v.flags = f;
        v.exp_ctrl = ec; v.exp_step = es; v.name = nm;
        vecs.push_back(v);
    endfunction

    // Drive one cycle, push the expectation, compare mid-cycle, advance.
    task automatic apply(input logic c, input logic [3:0] i, input logic [1:0] f,
                         input logic [15:0] ec, input logic [2:0] es,
                         input string nm);
        exp_t e;
        clear = c;
        instr = i;
        flags = f;
        e.ctrl = ec; e.step = es; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if (ctrl !== e.ctrl) begin
            n_fail++;
            $display("FAIL %s ctrl: got %h want %h", e.name, ctrl, e.ctrl);
        end
        n_tests++;
        if (step !== e.step) begin
            n_fail++;
            $display("FAIL %s step: got %0d want %0d", e.name, step, e.step);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b1;
        instr = 4'b0000;
        flags = 2'b00;
        @(posedge clk);
        #1;

        // reset then ADD / SUB; flags toggled where they must be ignored
        add(1, 4'b0010, 2'b11, 16'h0000, 3'd0, "rst_hold");
        add(0, 4'b0010, 2'b00, 16'h4004, 3'd0, "add_s0");
        add(0, 4'b0010, 2'b11, 16'h1408, 3'd1, "add_s1");
        add(0, 4'b0010, 2'b11, 16'h4800, 3'd2, "add_s2");
        add(0, 4'b0010, 2'b01, 16'h1020, 3'd3, "add_s3");
        add(0, 4'b0010, 2'b11, 16'h0281, 3'd4, "add_s4");
        add(0, 4'b0011, 2'b00, 16'h4004, 3'd0, "sub_s0");
        add(0, 4'b0011, 2'b00, 16'h1408, 3'd1, "sub_s1");
        add(0, 4'b0011, 2'b10, 16'h4800, 3'd2, "sub_s2");
        add(0, 4'b0011, 2'b00, 16'h1020, 3'd3, "sub_s3");
        add(0, 4'b0011, 2'b00, 16'h02C1, 3'd4, "sub_s4");
        // JC taken / not taken
        add(0, 4'b0111, 2'b10, 16'h4004, 3'd0, "jc_s0");
        add(0, 4'b0111, 2'b10, 16'h1408, 3'd1, "jc_s1");
        add(0, 4'b0111, 2'b10, 16'h0802, 3'd2, "jc_taken");
        add(0, 4'b0111, 2'b11, 16'h0000, 3'd3, "jc_s3");
        add(0, 4'b0111, 2'b11, 16'h0000, 3'd4, "jc_s4");
        add(0, 4'b0111, 2'b00, 16'h4004, 3'd0, "jc2_s0");
        add(0, 4'b0111, 2'b00, 16'h1408, 3'd1, "jc2_s1");
        add(0, 4'b0111, 2'b01, 16'h0000, 3'd2, "jc_not_taken");
        add(0, 4'b0111, 2'b00, 16'h0000, 3'd3, "jc2_s3");
        add(0, 4'b0111, 2'b00, 16'h0000, 3'd4, "jc2_s4");
        // JZ taken / not taken
        add(0, 4'b1000, 2'b01, 16'h4004, 3'd0, "jz_s0");
        add(0, 4'b1000, 2'b01, 16'h1408, 3'd1, "jz_s1");
        add(0, 4'b1000, 2'b01, 16'h0802, 3'd2, "jz_taken");
        add(0, 4'b1000, 2'b01, 16'h0000, 3'd3, "jz_s3");
        add(0, 4'b1000, 2'b01, 16'h0000, 3'd4, "jz_s4");
        add(0, 4'b1000, 2'b10, 16'h4004, 3'd0, "jz2_s0");
        add(0, 4'b1000, 2'b10, 16'h1408, 3'd1, "jz2_s1");
        add(0, 4'b1000, 2'b10, 16'h0000, 3'd2, "jz_not_taken");
        add(0, 4'b1000, 2'b10, 16'h0000, 3'd3, "jz2_s3");
        add(0, 4'b1000, 2'b10, 16'h0000, 3'd4, "jz2_s4");
        // undefined opcode acts as NOP
        add(0, 4'b1010, 2'b11, 16'h4004, 3'd0, "undef_s0");
        add(0, 4'b1010, 2'b11, 16'h1408, 3'd1, "undef_s1");
        add(0, 4'b1010, 2'b11, 16'h0000, 3'd2, "undef_s2");
        add(0, 4'b1010, 2'b11, 16'h0000, 3'd3, "undef_s3");
        add(0, 4'b1010, 2'b11, 16'h0000, 3'd4, "undef_s4");
        add(0, 4'b1010, 2'b00, 16'h4004, 3'd0, "undef_wrap");
        // remaining opcodes, execute steps only (fetch rows reused)
        add(0, 4'b0100, 2'b00, 16'h1408, 3'd1, "sta_s1");
        add(0, 4'b0100, 2'b00, 16'h4800, 3'd2, "sta_s2");
        add(0, 4'b0100, 2'b00, 16'h2100, 3'd3, "sta_s3");
        add(0, 4'b0100, 2'b00, 16'h0000, 3'd4, "sta_s4");
        add(0, 4'b0101, 2'b00, 16'h4004, 3'd0, "ldi_s0");
        add(0, 4'b0101, 2'b00, 16'h1408, 3'd1, "ldi_s1");
        add(0, 4'b0101, 2'b00, 16'h0A00, 3'd2, "ldi_s2");
        add(0, 4'b0110, 2'b00, 16'h0000, 3'd3, "jmp_s3");
        add(0, 4'b0110, 2'b00, 16'h0000, 3'd4, "jmp_s4");
        add(0, 4'b0110, 2'b00, 16'h4004, 3'd0, "jmp_s0");
        add(0, 4'b0110, 2'b00, 16'h1408, 3'd1, "jmp_s1");
        add(0, 4'b0110, 2'b00, 16'h0802, 3'd2, "jmp_s2");
        add(0, 4'b1110, 2'b00, 16'h0000, 3'd3, "out_s3");
        add(0, 4'b1110, 2'b00, 16'h0000, 3'd4, "out_s4");
        add(0, 4'b1110, 2'b00, 16'h4004, 3'd0, "out_s0");
        add(0, 4'b1110, 2'b00, 16'h1408, 3'd1, "out_s1");
        add(0, 4'b1110, 2'b00, 16'h0110, 3'd2, "out_s2");
        add(0, 4'b0000, 2'b11, 16'h0000, 3'd3, "nop_s3");
        add(0, 4'b0000, 2'b11, 16'h0000, 3'd4, "nop_s4");

        foreach (vecs[k])
            apply(vecs[k].clear, vecs[k].instr, vecs[k].flags,
                  vecs[k].exp_ctrl, vecs[k].exp_step, vecs[k].name);

        // halt: park at step 2 for 10 cycles, clear wins over the freeze
        apply(0, 4'b1111, 2'b00, 16'h4004, 3'd0, "hlt_s0");
        apply(0, 4'b1111, 2'b00, 16'h1408, 3'd1, "hlt_s1");
        for (int n = 0; n < 10; n++)
            apply(0, 4'b1111, 2'(n), 16'h8000, 3'd2, "hlt_park");
        apply(1, 4'b1111, 2'b00, 16'h0000, 3'd2, "hlt_clear");
        apply(0, 4'b1111, 2'b00, 16'h4004, 3'd0, "hlt_released");
        apply(0, 4'b0001, 2'b00, 16'h1408, 3'd1, "post_hlt_s1");

        // mid-instruction reset of LDA at step 3
        apply(0, 4'b0001, 2'b00, 16'h4800, 3'd2, "lda_s2");
        apply(1, 4'b0001, 2'b00, 16'h0000, 3'd3, "lda_clear_s3");
        apply(1, 4'b0001, 2'b00, 16'h0000, 3'd0, "lda_clear_held");
        apply(0, 4'b0001, 2'b00, 16'h4004, 3'd0, "lda_restart_s0");
        apply(0, 4'b0001, 2'b00, 16'h1408, 3'd1, "lda_restart_s1");
        apply(0, 4'b0001, 2'b00, 16'h4800, 3'd2, "lda_restart_s2");
        apply(0, 4'b0001, 2'b00, 16'h1200, 3'd3, "lda_s3");
        apply(0, 4'b0001, 2'b00, 16'h0000, 3'd4, "lda_s4");

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
